apb_completer: RTL and testbench
================================

# apb_completer

APB completer (slave) that answers transfers issued by the APB requester on the same bus: a word-addressed memory with programmable wait states and PSLVERR on out-of-range addresses. Two instances sit behind the requester's address decode, one per slave select. It also serves as the reference responder for the requester's verification environment.

## Interface
Parameters:
- AW, 8, address width of paddr
- DW, 8, data width of pwdata/prdata
- DEPTH, 256, number of DW-bit words implemented (DEPTH <= 2**AW)
- WAIT, 0, access-phase wait cycles inserted before pready (0..15)

Ports:
- pclk  in  1  bus clock; all state changes on rising edge
- presetn  in  1  reset, asynchronous, active-low
- psel  in  1  completer select
- penable  in  1  access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  AW  word address
- pwdata  in  DW  write data
- pready  out  1  transfer completes this cycle
- prdata  out  DW  read data, valid when pready=1 and pwrite=0
- pslverr  out  1  error response, valid only when pready=1

## Operation
- States: IDLE, ACCESS.
- IDLE: psel=1, penable=0 (setup) -> latch paddr/pwrite/pwdata, load cnt=WAIT, go ACCESS. penable=1 without a prior setup is ignored; stay IDLE.
- ACCESS: cnt decrements each cycle while nonzero; completing cycle is the one where pready=1. On completion return to IDLE.
- Write completes: if latched paddr < DEPTH, mem[paddr] <= latched pwdata at the edge ending the completing cycle; else no write and pslverr=1.
- Read completes: prdata = mem[paddr] if paddr < DEPTH; else prdata=0, pslverr=1.
- psel dropping to 0 while in ACCESS: abort, no write, outputs cleared, go IDLE.
- Address compare is unsigned on full AW bits; DEPTH = 2**AW makes pslverr unreachable.
- Memory contents cleared to 0 by reset.

## Timing
- Reset values: pready=0, prdata=0, pslverr=0, state=IDLE, cnt=0, all memory words 0. Reset mid-transfer discards the transfer (no write).
- pready, prdata and pslverr are registered. pready=1 for exactly one cycle: access cycle WAIT+1 (1-based, first penable cycle is 1).
- WAIT=0: setup cycle T, pready=1 in T+1. WAIT=n: pready=1 in T+1+n.
- prdata and pslverr are nonzero only in the pready cycle; 0 otherwise.
- Back-to-back: a new setup is accepted in the cycle directly after the pready cycle, giving 2 cycles per transfer at WAIT=0.
- Read-after-write to the same address in consecutive transfers returns the new data.

## Structure
- Package apb_completer_pkg: state enum (IDLE, ACCESS), default AW/DW/DEPTH constants, WAIT counter width (4 bits).
- Sub-module apb_completer_mem: DEPTH x DW array, one synchronous write port, combinational read port, async clear on presetn. The top holds the FSM, wait counter, range check and output registers.

## Test plan
- Reset check: hold presetn=0 for 3 cycles, release -> pready=0, prdata=0, pslverr=0; read addr 0x10 returns 0x00.
- WAIT=0: write 0xA5 to 0x10, then read 0x10 -> pready in 2nd cycle of each transfer, prdata=0xA5, pslverr=0.
- WAIT=3: read addr 0x05 after writing 0x3C -> pready exactly at access cycle 4, prdata=0x3C only in that cycle.
- DEPTH=128, AW=8: write 0x55 to 0x90 -> pslverr=1 with pready; read 0x90 -> prdata=0, pslverr=1; read 0x10 (0x90 mod 128) unchanged.
- Abort: WAIT=2, write 0xFF to 0x20, drop psel in 2nd access cycle -> no pready; later read 0x20 returns prior value.
- Reset mid-write (WAIT=2, presetn low in 1st access cycle) -> outputs 0 immediately; read 0x20 after release returns 0x00.

Source files
------------

// File: rtl/apb_completer_pkg.sv
// Shared types and default sizing for the APB completer slice.
package apb_completer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int AW_DEFAULT    = 8;
    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 256;
    localparam int CNT_W         = 4;
    localparam int WAIT_MAX      = (1 << CNT_W) - 1;

endpackage

// File: rtl/apb_completer_mem.sv
// Word memory for the APB completer: one synchronous write port, combinational read, cleared by reset.
module apb_completer_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: resetting every word forces flops rather than RAM macros; the contents must read back 0 after reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Guards the read when DEPTH is not a power of two.
    assign rdata = (int'(addr) < DEPTH) ? mem[addr] : '0;

endmodule

// File: rtl/apb_completer.sv
// APB completer: word memory with fixed access-phase wait states and PSLVERR on out-of-range addresses.
module apb_completer
    import apb_completer_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WAIT  = 0
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic          pready,
    output logic [DW-1:0] prdata,
    output logic          pslverr
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             write_q;

    logic [AW-1:0]    cur_addr;
    logic             cur_write;
    logic             in_range;
    logic [DW-1:0]    mem_rdata;
    logic [DW-1:0]    resp_rdata;
    logic             resp_err;
    logic             mem_we;

    // The response is registered one cycle ahead, so in IDLE it is computed from the live setup inputs.
    // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
    always_comb begin
        cur_addr   = (state == IDLE) ? paddr  : addr_q;
        cur_write  = (state == IDLE) ? pwrite : write_q;
        in_range   = int'(cur_addr) < DEPTH;
        resp_err   = !in_range;
        resp_rdata = (!cur_write && in_range) ? mem_rdata : '0;
        mem_we     = (state == ACCESS) && pready && psel && write_q && in_range;
    end

    apb_completer_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (mem_we),
        .addr    (cur_addr[IW-1:0]),
        .wdata   (wdata_q),
        .rdata   (mem_rdata)
    );

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    prdata  <= '0;
                    pslverr <= 1'b0;
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        cnt     <= CNT_W'(WAIT);
                        state   <= ACCESS;
                        if (WAIT == 0) begin
                            pready  <= 1'b1;
                            prdata  <= resp_rdata;
                            pslverr <= resp_err;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel || pready) begin
                        // Abort or completion: the write itself happens in the memory on this same edge.
                        pready  <= 1'b0;
                        prdata  <= '0;
                        pslverr <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                        if (cnt == CNT_W'(1)) begin
                            pready  <= 1'b1;
                            prdata  <= resp_rdata;
                            pslverr <= resp_err;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: three completers with different WAIT/DEPTH share one bus, each with its own select.
module tb_apb_completer;

    localparam int N = 3;
    localparam int WAITS  [N] = '{0, 3, 2};
    localparam int DEPTHS [N] = '{256, 256, 128};

    logic           pclk = 1'b0;
    logic           presetn;
    logic [N-1:0]   psel;
    logic           penable;
    logic           pwrite;
    logic [7:0]     paddr;
    logic [7:0]     pwdata;
    logic [N-1:0]   pready;
    logic [7:0]     prdata  [N];
    logic [N-1:0]   pslverr;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] mdl [N][256];

    always #5 pclk = ~pclk;

    apb_completer #(.AW(8), .DW(8), .DEPTH(256), .WAIT(0)) u_c0 (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );
    apb_completer #(.AW(8), .DW(8), .DEPTH(256), .WAIT(3)) u_c1 (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );
    apb_completer #(.AW(8), .DW(8), .DEPTH(128), .WAIT(2)) u_c2 (
        .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2])
    );

    typedef struct {
        int         s;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mdl_clear();
        for (int s = 0; s < N; s++)
            for (int a = 0; a < 256; a++)
                mdl[s][a] = 8'h00;
    endtask

    task automatic mdl_update(input int s, input bit wr, input logic [7:0] a, input logic [7:0] d);
        if (wr && int'(a) < DEPTHS[s]) mdl[s][a] = d;
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        psel    = '0;
        penable = 1'b0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;
        mdl_clear();
    endtask

    task automatic idle(input int n);
        @(posedge pclk);
        #1;
        psel    = '0;
        penable = 1'b0;
        @(negedge pclk);
        check("pready_single_cycle", {29'b0, pready}, 32'h0);
        repeat (n - 1) @(posedge pclk);
    endtask

    // One complete transfer; returns the response sampled in the pready cycle and its access-cycle number.
    task automatic xfer(input int s, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output bit er, output int lat);
        @(posedge pclk);
        #1;
        psel    = '0;
        psel[s] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(negedge pclk);
        check("setup_no_pready", {29'b0, pready}, 32'h0);
        @(posedge pclk);
        #1 penable = 1'b1;
        lat = 0;
        rd  = 8'h00;
        er  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge pclk);
            if (pready[s]) begin
                lat = k;
                rd  = prdata[s];
                er  = pslverr[s];
                break;
            end
            check("wait_outputs_zero", {23'b0, pslverr[s], prdata[s]}, 32'h0);
            if (k < 20) begin
                @(posedge pclk);
                #1;
            end
        end
        if (lat == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_timeout: completer %0d addr 0x%0h got no pready within 20 cycles, expected at %0d",
                     s, a, WAITS[s] + 1);
        end
    endtask

    logic [7:0] rd;
    bit         er;
    int         lat;

    initial begin
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        do_reset();

        @(negedge pclk);
        check("reset_pready",  {29'b0, pready},  32'h0);
        check("reset_pslverr", {29'b0, pslverr}, 32'h0);
        check("reset_prdata0", {24'b0, prdata[0]}, 32'h0);

        // Back-to-back table: reset content, WAIT=0/3 read-after-write, out-of-range and top-of-range words.
        vecs.push_back('{0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0});
        vecs.push_back('{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0});
        vecs.push_back('{1, 1'b1, 8'h05, 8'h3C, 8'h00, 1'b0});
        vecs.push_back('{1, 1'b0, 8'h05, 8'h00, 8'h3C, 1'b0});
        vecs.push_back('{2, 1'b1, 8'h10, 8'h77, 8'h00, 1'b0});
        vecs.push_back('{2, 1'b1, 8'h90, 8'h55, 8'h00, 1'b1});
        vecs.push_back('{2, 1'b0, 8'h90, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{2, 1'b0, 8'h10, 8'h00, 8'h77, 1'b0});
        vecs.push_back('{2, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{2, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{2, 1'b1, 8'h20, 8'h11, 8'h00, 1'b0});
        vecs.push_back('{0, 1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0});
        vecs.push_back('{0, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0});
        vecs.push_back('{1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0});

        foreach (vecs[i]) begin
            xfer(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("tbl%0d_latency", i), lat, WAITS[vecs[i].s] + 1);
            check($sformatf("tbl%0d_prdata", i), {24'b0, rd}, {24'b0, vecs[i].exp_rdata});
            check($sformatf("tbl%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            mdl_update(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
        end
        idle(2);

        // Abort: psel drops in the 2nd access cycle of a WAIT=2 write; the word keeps its old value.
        @(posedge pclk);
        #1;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'hFF;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        check("abort_c1_pready", {31'b0, pready[2]}, 32'h0);
        @(posedge pclk);
        #1;
        psel = '0; penable = 1'b0;
        @(negedge pclk);
        check("abort_c2_pready", {31'b0, pready[2]}, 32'h0);
        @(negedge pclk);
        check("abort_c3_pready", {31'b0, pready[2]}, 32'h0);
        xfer(2, 1'b0, 8'h20, 8'h00, rd, er, lat);
        check("abort_readback", {24'b0, rd}, {24'b0, mdl[2][8'h20]});

        // Randomized traffic against the array model.
        for (int i = 0; i < 80; i++) begin
            int         s;
            bit         wr;
            logic [7:0] a;
            logic [7:0] d;
            bit         exp_err;
            logic [7:0] exp_rd;
            s  = $urandom_range(0, N - 1);
            wr = 1'($urandom_range(0, 1));
            a  = (i % 4 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            d  = 8'($urandom);
            exp_err = int'(a) >= DEPTHS[s];
            exp_rd  = (wr || exp_err) ? 8'h00 : mdl[s][a];
            xfer(s, wr, a, d, rd, er, lat);
            check("rnd_latency", lat, WAITS[s] + 1);
            check("rnd_prdata", {24'b0, rd}, {24'b0, exp_rd});
            check("rnd_pslverr", {31'b0, er}, {31'b0, exp_err});
            mdl_update(s, wr, a, d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        // Asynchronous reset landing in a pready cycle clears the outputs without waiting for a clock.
        @(posedge pclk);
        #1;
        psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        check("pre_reset_pready", {31'b0, pready[0]}, 32'h1);
        check("pre_reset_prdata", {24'b0, prdata[0]}, {24'b0, mdl[0][8'h10]});
        #1 presetn = 1'b0;
        #1;
        check("async_reset_pready", {31'b0, pready[0]}, 32'h0);
        check("async_reset_prdata", {24'b0, prdata[0]}, 32'h0);
        psel = '0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        mdl_clear();

        // Reset in the 1st access cycle of a WAIT=2 write discards it; memory reads back 0.
        xfer(2, 1'b1, 8'h20, 8'h5A, rd, er, lat);
        mdl_update(2, 1'b1, 8'h20, 8'h5A);
        xfer(1, 1'b1, 8'h05, 8'h3C, rd, er, lat);
        mdl_update(1, 1'b1, 8'h05, 8'h3C);
        idle(1);
        @(posedge pclk);
        #1;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h99;
        @(posedge pclk);
        #1 penable = 1'b1;
        #1 presetn = 1'b0;
        #1;
        check("midwrite_reset_outputs", {29'b0, pready | pslverr}, 32'h0);
        psel = '0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        mdl_clear();
        xfer(2, 1'b0, 8'h20, 8'h00, rd, er, lat);
        check("midwrite_readback", {24'b0, rd}, {24'b0, mdl[2][8'h20]});
        xfer(1, 1'b0, 8'h05, 8'h00, rd, er, lat);
        check("reset_cleared_mem", {24'b0, rd}, {24'b0, mdl[1][8'h05]});
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
